ras_checkpointed: RTL

- Return-address stack for the frontend branch predictor. Depth comes from the RASDepth field of the built cva6_cfg_t. Address width is VLEN.
- Predicted call instructions push their return address; predicted returns pop the stack.
- A single checkpoint captures the speculative stack state when a branch is predicted. The frontend restores from it when that branch resolves as mispredicted, which undoes wrong-path push/pop damage without shadowing the whole stack.

---
 rtl/ras_checkpointed.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ras_checkpointed.sv
`default_nettype none
// ============================================================================
// Module      : ras_checkpointed
// Description : Return-address stack for the frontend branch predictor with a
//               single speculative checkpoint. The checkpoint repairs the top
//               entry and the stack pointers when a branch mispredicts.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_checkpointed #(
    parameter int RASDepth = 2,
    parameter int VLEN     = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] ret_addr_i,
    input  logic            save_i,
    input  logic            restore_i,
    output logic [VLEN-1:0] top_o,
    output logic            top_valid_o,
    output logic            ckpt_valid_o
);

    localparam int TW = $clog2(RASDepth);
    localparam int CW = $clog2(RASDepth + 1);

    localparam logic [TW-1:0] c_last_idx = TW'(RASDepth - 1);
    localparam logic [CW-1:0] c_full_cnt = CW'(RASDepth);

    logic [VLEN-1:0] entry_q [RASDepth];
    logic [VLEN-1:0] entry_d [RASDepth];
    logic [TW-1:0]   tos_q, tos_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   ck_tos_q, ck_tos_d;
    logic [CW-1:0]   ck_count_q, ck_count_d;
    logic [VLEN-1:0] ck_top_q, ck_top_d;
    logic            ck_valid_q, ck_valid_d;

    logic [TW-1:0]   w_next_tos;
    logic [TW-1:0]   w_prev_tos;

    // Circular index neighbours of the top; wrap is explicit so the depth
    // need not be a power of two.
    always_comb begin
        w_next_tos = (tos_q == c_last_idx) ? '0 : tos_q + TW'(1);
        w_prev_tos = (tos_q == '0) ? c_last_idx : tos_q - TW'(1);
    end

    // Next-state selection: flush beats restore, restore beats push/pop.
    always_comb begin
        entry_d    = entry_q;
        tos_d      = tos_q;
        count_d    = count_q;
        ck_tos_d   = ck_tos_q;
        ck_count_d = ck_count_q;
        ck_top_d   = ck_top_q;
        ck_valid_d = ck_valid_q;

        if (flush_i) begin
            // Entries are left alone; they are unobservable while empty.
            tos_d      = '0;
            count_d    = '0;
            ck_valid_d = 1'b0;
        end else if (restore_i) begin
            // A concurrent save would recapture exactly the restored state,
            // so leaving the checkpoint untouched covers that case too.
            if (ck_valid_q) begin
                tos_d             = ck_tos_q;
                count_d           = ck_count_q;
                entry_d[ck_tos_q] = ck_top_q;
            end
        end else begin
            if (push_i && pop_i && (count_q != '0)) begin
                // Return followed by call: replace the top in place.
                entry_d[tos_q] = ret_addr_i;
            end else if (push_i) begin
                // When full this overwrites the oldest entry.
                entry_d[w_next_tos] = ret_addr_i;
                tos_d               = w_next_tos;
                count_d             = (count_q == c_full_cnt) ? count_q : count_q + CW'(1);
            end else if (pop_i && (count_q != '0)) begin
                tos_d   = w_prev_tos;
                count_d = count_q - CW'(1);
            end

            // Checkpoint records the state as it stood before this cycle.
            if (save_i) begin
                ck_tos_d   = tos_q;
                ck_count_d = count_q;
                ck_top_d   = entry_q[tos_q];
                ck_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RASDepth; i++) begin
                entry_q[i] <= '0;
            end
            tos_q      <= '0;
            count_q    <= '0;
            ck_tos_q   <= '0;
            ck_count_q <= '0;
            ck_top_q   <= '0;
            ck_valid_q <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            tos_q      <= tos_d;
            count_q    <= count_d;
            ck_tos_q   <= ck_tos_d;
            ck_count_q <= ck_count_d;
            ck_top_q   <= ck_top_d;
            ck_valid_q <= ck_valid_d;
        end
    end

    // Outputs depend on registers only.
    always_comb begin
        top_o        = entry_q[tos_q];
        top_valid_o  = (count_q != '0);
        ckpt_valid_o = ck_valid_q;
    end

endmodule
`default_nettype wire
